// File: rtl/video_pixel_pipe.sv
// Windowed framebuffer address generator and 8-bit-to-RGB colouriser. The sync/enable
// signals are delayed so they stay aligned with the colour. Define VIDEO_PIXEL_PIPE_TESTPAT_EN for test bars.
module video_pixel_pipe #(
  parameter int          ADDR_W     = 16,
  parameter int          IMG_W      = 256,
  parameter int          IMG_H      = 256,
  parameter int          X0         = 192,
  parameter int          Y0         = 112,
  parameter int          SCALE_LOG2 = 0,
  parameter int          RD_LAT     = 1,
  parameter logic [7:0]  FG_CODE    = 8'h01,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              de,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [1:0]        mode,
`ifdef VIDEO_PIXEL_PIPE_TESTPAT_EN
  input  logic              test_en,
`endif
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        pixel,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + (IMG_W << SCALE_LOG2) - 1);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + (IMG_H << SCALE_LOG2) - 1);

  typedef struct packed {
    logic [1:0] mode;
    logic       in_img;
    logic       de;
    logic       hs;
    logic       vs;
`ifdef VIDEO_PIXEL_PIPE_TESTPAT_EN
    logic       tp;
    logic [2:0] bar;
`endif
  } flags_t;

  logic [10:0]       w_x, w_y, w_xi, w_yi;
  logic              w_in_img;
  logic [ADDR_W-1:0] w_addr;
  flags_t            w_stage0, w_last;
  logic [23:0]       w_rgb;

  logic [ADDR_W-1:0] r_address;
  logic [1:0]        r_mode;
  logic              r_vs_prev, r_armed;
  flags_t            r_pipe [RD_LAT+1];
  logic [23:0]       r_rgb;
  logic              r_de_out, r_hs_out, r_vs_out;

  assign w_x      = {1'b0, x};
  assign w_y      = {1'b0, y};
  assign w_in_img = de && (w_x >= X_LO) && (w_x <= X_HI) && (w_y >= Y_LO) && (w_y <= Y_HI);
  assign w_xi     = (w_x - X_LO) >> SCALE_LOG2;
  assign w_yi     = (w_y - Y_LO) >> SCALE_LOG2;
  assign w_addr   = w_in_img ? (ADDR_W'(w_yi) * ADDR_W'(IMG_W) + ADDR_W'(w_xi)) : '0;

  always_comb begin
    w_stage0        = '0;
    w_stage0.mode   = r_mode;
    w_stage0.in_img = w_in_img;
    w_stage0.de     = de;
    w_stage0.hs     = hsync_in;
    w_stage0.vs     = vsync_in;
`ifdef VIDEO_PIXEL_PIPE_TESTPAT_EN
    w_stage0.tp     = test_en;
    w_stage0.bar    = w_xi[7:5];
`endif
  end

  // r_armed blocks a vsync fall that coincides with the first clock after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_address <= '0;
      r_mode    <= 2'd0;
      r_vs_prev <= 1'b1;
      r_armed   <= 1'b0;
    end else begin
      r_address <= w_addr;
      r_armed   <= 1'b1;
      r_vs_prev <= vsync_in;
      if (r_armed && r_vs_prev && !vsync_in)
        r_mode <= mode;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= RD_LAT; gi++) begin : g_dly
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_pipe[gi]    <= '0;
          r_pipe[gi].hs <= 1'b1;
          r_pipe[gi].vs <= 1'b1;
        end else if (gi == 0) begin
          r_pipe[gi] <= w_stage0;
        end else begin
          r_pipe[gi] <= r_pipe[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign w_last = r_pipe[RD_LAT];

  always_comb begin
    w_rgb = 24'h000000;
    if (!w_last.de)
      w_rgb = 24'h000000;
    else if (!w_last.in_img)
      w_rgb = BORDER_RGB;
`ifdef VIDEO_PIXEL_PIPE_TESTPAT_EN
    else if (w_last.tp)
      w_rgb = {{8{~w_last.bar[1]}}, {8{~w_last.bar[2]}}, {8{~w_last.bar[0]}}};
`endif
    else begin
      case (w_last.mode)
        2'd1:    w_rgb = {pixel, pixel, pixel};
        2'd2:    w_rgb = {pixel[7:5], pixel[7:5], pixel[7:6],
                          pixel[4:2], pixel[4:2], pixel[4:3],
                          {4{pixel[1:0]}}};
        default: w_rgb = (pixel == FG_CODE) ? 24'hFFFFFF : 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb    <= 24'hFFFFFF;
      r_de_out <= 1'b0;
      r_hs_out <= 1'b1;
      r_vs_out <= 1'b1;
    end else begin
      r_rgb    <= w_rgb;
      r_de_out <= w_last.de;
      r_hs_out <= w_last.hs;
      r_vs_out <= w_last.vs;
    end
  end

  assign address   = r_address;
  assign {r, g, b} = r_rgb;
  assign de_out    = r_de_out;
  assign hsync_out = r_hs_out;
  assign vsync_out = r_vs_out;

endmodule
